parking_lot_controller: RTL and testbench
=========================================

Name: parking_lot_controller

Overview:
Occupancy and entry-gate controller for the parking lot. It consumes the one-cycle enter/exit pulses from the lot's car detector and keeps a saturating occupancy count with full/empty flags. It also sequences the entry gate arm: a driver's entry request opens the gate only when a space is free, and the gate closes after the car is detected entering or after a timeout. It sits between the car detector and the gate actuator and status display.

Parameters:
CAPACITY, 25, number of spaces; legal range 1..(2**COUNT_W)-1
COUNT_W, 5, width of the occupancy count
GATE_TIMEOUT, 8, cycles the gate stays open without a detected entry; legal range >= 2
TIMER_W, 4, width of the gate timer; must hold GATE_TIMEOUT-1

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
req  input  1  entry request from the ticket button; level, held by the driver
enter  input  1  car-entered pulse from the detector, 1 cycle
exit  input  1  car-exited pulse from the detector, 1 cycle
gate_open  output  1  entry gate arm command; 1 = raised
count  output  COUNT_W  current occupancy
full  output  1  count == CAPACITY
empty  output  1  count == 0
denied  output  1  1-cycle pulse: request refused because the lot is full
timeout  output  1  1-cycle pulse: gate closed without a detected entry
err  output  1  sticky: entry at capacity or exit at zero was detected

Behaviour:
- Reset, synchronous and active-high, takes priority over all other inputs. After reset: count=0, gate FSM in S_CLOSED, timer=0, err=0, req_d=0. Outputs after reset: gate_open=0, full=0, empty=1, denied=0, timeout=0. Reset asserted mid-operation aborts an open gate and clears the count.
- Occupancy, registered:
  - enter only: count+1.
  - exit only: count-1.
  - enter and exit in the same cycle: count unchanged, no err.
  - enter only with count==CAPACITY: count holds, err<=1.
  - exit only with count==0: count holds, err<=1.
  - err clears only on reset.
- full and empty are decoded combinationally from the count register.
- enter is counted in every gate state, so tailgating is still tracked.
- Gate FSM, two states. gate_open = (ps==S_OPEN), a Moore output.
  - S_CLOSED:
    - req & ~req_d & ~full: go to S_OPEN, timer<=0.
    - req & ~req_d & full: denied=1 for this cycle only, stay in S_CLOSED.
    - A held req never re-triggers. A new rising edge is required after a denial or a close.
  - S_OPEN:
    - enter=1: go to S_CLOSED. gate_open is 0 from the next cycle.
    - else if timer==GATE_TIMEOUT-1: timeout=1 for this cycle, go to S_CLOSED.
    - else: timer+1.
    - If enter and the timeout condition occur in the same cycle, enter wins: no timeout pulse.
    - An exit pulse in S_OPEN only decrements count; the FSM is unaffected.
- Latency:
  - req rising edge sampled at clock edge N: gate_open=1 after edge N.
  - With no enter: gate_open stays high for exactly GATE_TIMEOUT cycles.
  - denied and timeout are Mealy, combinational, asserted in the cycle the condition holds.
- req_d is a registered copy of req, used for edge detection.
- Known limitation: full is evaluated at grant time only; a space is not reserved while the gate is open. An over-entry while the gate is open sets err.

Test Plan:
(CAPACITY=3, GATE_TIMEOUT=4)
1. Reset, then idle 3 cycles -> count=0, empty=1, full=0, gate_open=0, err=0.
2. req rises, held high -> gate_open=1 the next cycle; enter pulse 2 cycles later -> count=1, gate_open=0 the following cycle, timeout never asserted; req still held -> gate stays closed.
3. req pulse, no enter -> gate_open high exactly 4 cycles; timeout=1 in the last S_OPEN cycle; count unchanged.
4. Three grant+enter sequences -> count=3, full=1; new req rising edge -> denied=1 for 1 cycle, gate_open stays 0; enter pulse (tailgater) -> count stays 3, err=1.
5. At count=2, enter and exit in the same cycle -> count=2, err unchanged; at count=0, exit pulse -> count=0, err=1.
6. Gate open after a grant, reset asserted for 1 cycle -> gate_open=0, count=0, err=0, empty=1 on the next cycle.

Source files
------------

// File: rtl/parking_lot_controller.sv
// Parking lot occupancy counter and entry gate sequencer.
// Tracks cars in the lot and opens the entry gate on a fresh request when space is free.
module parking_lot_controller #(
    parameter int CAPACITY     = 25,
    parameter int COUNT_W      = 5,
    parameter int GATE_TIMEOUT = 8,
    parameter int TIMER_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req,
    input  logic               enter,
    input  logic               exit,
    output logic               gate_open,
    output logic [COUNT_W-1:0] count,
    output logic               full,
    output logic               empty,
    output logic               denied,
    output logic               timeout,
    output logic               err
);

    typedef enum logic {
        S_CLOSED = 1'b0,
        S_OPEN   = 1'b1
    } state_t;

    localparam logic [COUNT_W-1:0] CAP   = COUNT_W'(CAPACITY);
    localparam logic [TIMER_W-1:0] TLAST = TIMER_W'(GATE_TIMEOUT - 1);

    state_t             ps;
    logic [TIMER_W-1:0] timer;
    logic               req_d;
    logic [COUNT_W-1:0] cnt;
    logic               err_q;
    logic               rise;
    logic               tmo_hit;

    assign rise      = req & ~req_d;
    assign full      = (cnt == CAP);
    assign empty     = (cnt == '0);
    assign count     = cnt;
    assign err       = err_q;
    assign gate_open = (ps == S_OPEN);

    // Timeout fires only if no car entered this cycle; an entry closes the gate normally.
    assign tmo_hit = (ps == S_OPEN) & ~enter & (timer == TLAST);
    assign timeout = ~reset & tmo_hit;
    assign denied  = ~reset & (ps == S_CLOSED) & rise & full;

    // Saturating occupancy count; simultaneous enter/exit cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            case ({enter, exit})
                2'b10: begin
                    if (full) err_q <= 1'b1;
                    else      cnt   <= cnt + 1'b1;
                end
                2'b01: begin
                    if (empty) err_q <= 1'b1;
                    else       cnt   <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Gate sequencer: open on a request edge with space free, close on entry or timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps    <= S_CLOSED;
            timer <= '0;
            req_d <= 1'b0;
        end else begin
            req_d <= req;
            case (ps)
                S_CLOSED: begin
                    if (rise && !full) begin
                        ps    <= S_OPEN;
                        timer <= '0;
                    end
                end
                S_OPEN: begin
                    if (enter)              ps    <= S_CLOSED;
                    else if (timer == TLAST) ps   <= S_CLOSED;
                    else                    timer <= timer + 1'b1;
                end
                default: ps <= S_CLOSED;
            endcase
        end
    end

endmodule

// File: tb/tb_parking_lot_controller.sv
// Scoreboard bench for parking_lot_controller.
// Directed test-plan sequences followed by randomized traffic against a reference model.
module tb_parking_lot_controller;

    localparam int CAP = 3;
    localparam int CW  = 4;
    localparam int GT  = 4;
    localparam int TW  = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req = 1'b0;
    logic          enter = 1'b0;
    logic          exit = 1'b0;
    logic          gate_open;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          denied;
    logic          timeout;
    logic          err;

    parking_lot_controller #(
        .CAPACITY    (CAP),
        .COUNT_W     (CW),
        .GATE_TIMEOUT(GT),
        .TIMER_W     (TW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .enter    (enter),
        .exit     (exit),
        .gate_open(gate_open),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .denied   (denied),
        .timeout  (timeout),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef logic [CW+5:0] obs_t;

    obs_t sbq[$];
    int   cmp_n = 0;
    int   bad_n = 0;
    int   cyc_n = 0;

    // Reference model: cars in lot, whether the arm is up and for how many cycles.
    int m_occ = 0;
    int m_open = 0;
    int m_open_cyc = 0;
    int m_err = 0;
    int m_reqd = 0;
    int m_valid = 0;

    function automatic obs_t pack(int g, int c, int f, int e, int d, int t, int r);
        obs_t o;
        o = {g[0], CW'(c), f[0], e[0], d[0], t[0], r[0]};
        return o;
    endfunction

    task automatic cyc(input logic r, input logic rq, input logic en, input logic ex);
        int rise_i;
        int den;
        int tmo;
        @(negedge clk);
        reset = r;
        req   = rq;
        enter = en;
        exit  = ex;
        #1;
        cyc_n++;
        rise_i = (rq && !m_reqd) ? 1 : 0;
        den = (!r && !m_open && rise_i && m_occ == CAP) ? 1 : 0;
        tmo = (!r && m_open && !en && (m_open_cyc + 1 == GT)) ? 1 : 0;
        if (m_valid)
            sbq.push_back(pack(m_open, m_occ, m_occ == CAP, m_occ == 0,
                               den, tmo, m_err));
        if (r) begin
            m_occ = 0; m_open = 0; m_open_cyc = 0; m_err = 0; m_reqd = 0;
            m_valid = 1;
        end else begin
            if (!m_open) begin
                if (rise_i && m_occ < CAP) begin
                    m_open = 1;
                    m_open_cyc = 0;
                end
            end else begin
                if (en || m_open_cyc + 1 == GT) m_open = 0;
                else m_open_cyc++;
            end
            if (en && !ex) begin
                if (m_occ == CAP) m_err = 1;
                else m_occ++;
            end else if (ex && !en) begin
                if (m_occ == 0) m_err = 1;
                else m_occ--;
            end
            m_reqd = rq;
        end
    endtask

    // Monitor: pop one expectation per cycle and compare against the DUT.
    initial begin
        obs_t exp_v;
        obs_t act;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                exp_v = sbq.pop_front();
                act = {gate_open, count, full, empty, denied, timeout, err};
                cmp_n++;
                if (act !== exp_v) begin
                    bad_n++;
                    $display("FAIL outputs cyc=%0d got g=%b c=%0d f=%b e=%b d=%b t=%b r=%b want g=%b c=%0d f=%b e=%b d=%b t=%b r=%b",
                             cyc_n, act[CW+5], act[CW+4:5], act[4], act[3], act[2], act[1], act[0],
                             exp_v[CW+5], exp_v[CW+4:5], exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
                end
            end
        end
    end

    initial begin
        bit rq;
        int pr;
        // 1: reset and idle
        cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0);
        // 2: grant, enter two cycles later, held req does not re-trigger
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        repeat (3) cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        // 3: req pulse, no enter -> timeout
        cyc(0, 1, 0, 0);
        repeat (6) cyc(0, 0, 0, 0);
        // 4: fill the lot, then denial and tailgater
        repeat (2) begin
            cyc(0, 1, 0, 0);
            cyc(0, 0, 1, 0);
            cyc(0, 0, 0, 0);
        end
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        // 5: simultaneous enter/exit, then drain and underflow
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        // 6: reset while gate open
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        // Randomized traffic
        rq = 0;
        for (int i = 0; i < 3000; i++) begin
            pr = $urandom_range(0, 99);
            if ($urandom_range(0, 5) == 0) rq = ~rq;
            cyc(pr == 0, rq,
                $urandom_range(0, 99) < 25,
                $urandom_range(0, 99) < 22);
        end
        cyc(0, 0, 0, 0);
        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
        #3;
        if (sbq.size() != 0) begin
            bad_n++;
            $display("FAIL drain pending=%0d want 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
        $finish;
    end

endmodule
